// File: rtl/ps2_host_tx_if.sv
// Host-side handshake bundle for the PS/2 host transmitter: command request
// plus busy/done/error status.
interface ps2_host_tx_if;
    logic       send;
    logic [7:0] cmd;
    logic       busy;
    logic       done;
    logic       error;

    modport master (output send, output cmd, input busy, input done, input error);
    modport slave  (input send, input cmd, output busy, output done, output error);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter: inhibit, start, 8 data bits LSB first,
// odd parity, stop, ack. Define PS2_TX_ACK_CHECK_EN to turn a high ack bit into an error.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic         clock,
    input  logic         resetn,
    input  logic         ps2_clock_in,
    input  logic         ps2_data_in,
    output logic         ps2_clock_oe,
    output logic         ps2_data_oe,
    ps2_host_tx_if.slave host
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INHIBIT = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        ACK     = 3'd5
    } state_t;

    // Odd parity bit: set when the byte holds an even number of ones.
    function automatic logic odd_parity(input logic [7:0] byte_in);
        return ~(^byte_in);
    endfunction

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [2:0]         idx_r, idx_s;
    logic [7:0]         cmd_r, cmd_s;
    logic               parity_r, parity_s;
    logic               clock_oe_r, clock_oe_s;
    logic               data_oe_r, data_oe_s;
    logic               busy_r, busy_s;
    logic               done_r, done_s;
    logic               error_r, error_s;

    logic               clk_meta_r, clk_sync_r, clk_prev_r;
    logic               data_meta_r, data_sync_r;
    logic               fall_s;
    logic               in_xfer_s;
    logic               timeout_s;
    logic               nack_s;

    assign fall_s    = clk_prev_r & ~clk_sync_r;
    assign in_xfer_s = (state_r == DATA) || (state_r == PARITY) ||
                       (state_r == STOP) || (state_r == ACK);
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // The data line is synchronized in both builds; only the checked build acts on it.
`ifdef PS2_TX_ACK_CHECK_EN
    assign nack_s = data_sync_r;
`else
    assign nack_s = data_sync_r & 1'b0;
`endif

    // Two-stage synchronizers on both raw lines plus the clock edge history.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            clk_meta_r  <= 1'b1;
            clk_sync_r  <= 1'b1;
            clk_prev_r  <= 1'b1;
            data_meta_r <= 1'b1;
            data_sync_r <= 1'b1;
        end else begin
            clk_meta_r  <= ps2_clock_in;
            clk_sync_r  <= clk_meta_r;
            clk_prev_r  <= clk_sync_r;
            data_meta_r <= ps2_data_in;
            data_sync_r <= data_meta_r;
        end
    end

    // Next-state and next-output logic for the transfer sequencer.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        idx_s      = idx_r;
        cmd_s      = cmd_r;
        parity_s   = parity_r;
        clock_oe_s = clock_oe_r;
        data_oe_s  = data_oe_r;
        busy_s     = busy_r;
        done_s     = 1'b0;
        error_s    = 1'b0;

        case (state_r)
            IDLE: begin
                clock_oe_s = 1'b0;
                data_oe_s  = 1'b0;
                busy_s     = 1'b0;
                cnt_s      = {CNT_W{1'b0}};
                idx_s      = 3'd0;
                if (host.send) begin
                    cmd_s      = host.cmd;
                    parity_s   = odd_parity(host.cmd);
                    busy_s     = 1'b1;
                    clock_oe_s = 1'b1;
                    state_s    = INHIBIT;
                end else begin
                    state_s    = IDLE;
                end
            end
            INHIBIT: begin
                if (cnt_r == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    clock_oe_s = 1'b0;
                    data_oe_s  = 1'b1;
                    cnt_s      = {CNT_W{1'b0}};
                    idx_s      = 3'd0;
                    state_s    = DATA;
                end else begin
                    cnt_s      = cnt_r + CNT_W'(1);
                end
            end
            DATA: begin
                if (fall_s) begin
                    data_oe_s = ~cmd_r[idx_r];
                    idx_s     = idx_r + 3'd1;
                    state_s   = (idx_r == 3'd7) ? PARITY : DATA;
                end else begin
                    state_s   = DATA;
                end
            end
            PARITY: begin
                if (fall_s) begin
                    data_oe_s = ~parity_r;
                    state_s   = STOP;
                end else begin
                    state_s   = PARITY;
                end
            end
            STOP: begin
                if (fall_s) begin
                    data_oe_s = 1'b0;
                    state_s   = ACK;
                end else begin
                    state_s   = STOP;
                end
            end
            ACK: begin
                if (fall_s) begin
                    done_s    = ~nack_s;
                    error_s   = nack_s;
                    busy_s    = 1'b0;
                    data_oe_s = 1'b0;
                    state_s   = IDLE;
                end else begin
                    state_s   = ACK;
                end
            end
            default: begin
                clock_oe_s = 1'b0;
                data_oe_s  = 1'b0;
                busy_s     = 1'b0;
                state_s    = IDLE;
            end
        endcase

        // Timeout wins over a coincident ack edge so done and error stay exclusive.
        if (in_xfer_s) begin
            if (timeout_s) begin
                done_s     = 1'b0;
                error_s    = 1'b1;
                clock_oe_s = 1'b0;
                data_oe_s  = 1'b0;
                busy_s     = 1'b0;
                cnt_s      = {CNT_W{1'b0}};
                state_s    = IDLE;
            end else begin
                cnt_s      = cnt_r + CNT_W'(1);
            end
        end else begin
            done_s = done_s;
        end
    end

    // State register and registered outputs.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_r    <= IDLE;
            cnt_r      <= {CNT_W{1'b0}};
            idx_r      <= 3'd0;
            cmd_r      <= 8'h00;
            parity_r   <= 1'b0;
            clock_oe_r <= 1'b0;
            data_oe_r  <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            idx_r      <= idx_s;
            cmd_r      <= cmd_s;
            parity_r   <= parity_s;
            clock_oe_r <= clock_oe_s;
            data_oe_r  <= data_oe_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
            error_r    <= error_s;
        end
    end

    assign ps2_clock_oe = clock_oe_r;
    assign ps2_data_oe  = data_oe_r;
    assign host.busy    = busy_r;
    assign host.done    = done_r;
    assign host.error   = error_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host while a scoreboard holds the expected frame and outcome per send.
module tb_ps2_host_tx;

    localparam int INH  = 50;
    localparam int TO   = 2000;
    localparam int HALF = 20;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic ps2_clock_oe, ps2_data_oe;
    logic ps2_clock_in, ps2_data_in;
    logic dev_clk      = 1'b1;
    logic dev_data_low = 1'b0;

    always #5 clock = ~clock;

    assign ps2_clock_in = ~ps2_clock_oe & dev_clk;
    assign ps2_data_in  = ~ps2_data_oe & ~dev_data_low;

    ps2_host_tx_if host ();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .ps2_clock_in (ps2_clock_in),
        .ps2_data_in  (ps2_data_in),
        .ps2_clock_oe (ps2_clock_oe),
        .ps2_data_oe  (ps2_data_oe),
        .host         (host)
    );

    typedef struct {
        logic [9:0] frame;
        bit         exp_done;
    } exp_t;

    exp_t sb[$];

    int checks     = 0;
    int failures   = 0;
    int done_cnt   = 0;
    int err_cnt    = 0;
    int inh_run    = 0;
    int last_inh   = 0;
    logic prev_done = 1'b0;
    logic prev_err  = 1'b0;
    logic prev_coe  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse counting, pulse shape and inhibit length, sampled on the falling clock edge.
    always @(negedge clock) begin
        if (host.done) done_cnt++;
        if (host.error) err_cnt++;
        if (host.done || host.error) begin
            checks++;
            assert (!(host.done && host.error) && !(host.done && prev_done) && !(host.error && prev_err)) else begin
                failures++;
                $error("FAIL pulse_shape observed=done%0b/err%0b prev=%0b/%0b expected=single one-cycle pulse",
                       host.done, host.error, prev_done, prev_err);
            end
        end
        if (ps2_clock_oe) inh_run++;
        else if (prev_coe) last_inh = inh_run;
        if (!ps2_clock_oe) inh_run = 0;
        prev_done = host.done;
        prev_err  = host.error;
        prev_coe  = ps2_clock_oe;
    end

    task automatic do_send(input logic [7:0] c);
        @(negedge clock);
        host.send = 1'b1;
        host.cmd  = c;
        @(negedge clock);
        host.send = 1'b0;
        host.cmd  = 8'h00;
    endtask

    task automatic push_send(input logic [7:0] c, input logic par, input bit exp_done);
        exp_t e;
        e.frame    = {1'b1, par, c};
        e.exp_done = exp_done;
        sb.push_back(e);
        do_send(c);
        chk("busy_after_send", host.busy, 1);
        chk("clock_inhibit", ps2_clock_oe, 1);
    endtask

    task automatic wait_start();
        int w = 0;
        while (!(ps2_data_oe && !ps2_clock_oe) && w < INH + 20) begin
            @(negedge clock);
            w++;
        end
        chk("start_seen", (w < INH + 20), 1);
    endtask

    task automatic dev_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b1;
        end
    endtask

    task automatic dev_run(input bit ack_low, output logic [9:0] frame);
        frame = 10'h000;
        wait_start();
        for (int i = 0; i < 11; i++) begin
            if (i == 10 && ack_low) dev_data_low = 1'b1;
            repeat (HALF) @(negedge clock);
            dev_clk = 1'b0;
            repeat (HALF) @(negedge clock);
            if (i < 10) frame[i] = ps2_data_in;
            dev_clk = 1'b1;
        end
        repeat (HALF) @(negedge clock);
        dev_data_low = 1'b0;
    endtask

    task automatic finish_xfer(input logic [9:0] frame, input int d0, input int e0);
        exp_t e;
        repeat (4) @(negedge clock);
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 0, 1);
        end else begin
            e = sb.pop_front();
            chk("frame", frame, e.frame);
            chk("done_count", done_cnt - d0, e.exp_done ? 1 : 0);
            chk("error_count", err_cnt - e0, e.exp_done ? 0 : 1);
        end
        chk("busy_idle", host.busy, 0);
        chk("lines_released", {ps2_clock_oe, ps2_data_oe}, 2'b00);
    endtask

    initial begin
        logic [9:0] frame;
        int d0, e0, k;
        host.send = 1'b0;
        host.cmd  = 8'h00;

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_clock_oe", ps2_clock_oe, 0);
        chk("rst_data_oe", ps2_data_oe, 0);
        chk("rst_busy", host.busy, 0);
        chk("rst_done", host.done, 0);
        chk("rst_error", host.error, 0);
        resetn = 1'b1;
        repeat (2) @(negedge clock);

        // 8'hED, ack low
        d0 = done_cnt; e0 = err_cnt;
        push_send(8'hED, 1'b1, 1'b1);
        dev_run(1'b1, frame);
        chk("inhibit_len", last_inh, INH);
        finish_xfer(frame, d0, e0);

        // 8'h00, device leaves data high at ack
        d0 = done_cnt; e0 = err_cnt;
`ifdef PS2_TX_ACK_CHECK_EN
        push_send(8'h00, 1'b1, 1'b0);
`else
        push_send(8'h00, 1'b1, 1'b1);
`endif
        dev_run(1'b0, frame);
        finish_xfer(frame, d0, e0);

        // device never clocks: timeout
        d0 = done_cnt; e0 = err_cnt;
        do_send(8'h55);
        k = 0;
        while (ps2_clock_oe && k < INH + 10) begin
            @(negedge clock);
            k++;
        end
        chk("to_release_seen", ps2_clock_oe, 0);
        k = 0;
        while (!host.error && k < TO + 10) begin
            @(negedge clock);
            k++;
        end
        chk("timeout_cycles", k, TO);
        chk("timeout_lines", {ps2_clock_oe, ps2_data_oe}, 2'b00);
        @(negedge clock);
        chk("timeout_busy", host.busy, 0);
        chk("timeout_done", done_cnt - d0, 0);
        chk("timeout_error", err_cnt - e0, 1);

        // 8'hF4 with an 8'hFF send injected during DATA
        d0 = done_cnt; e0 = err_cnt;
        push_send(8'hF4, 1'b0, 1'b1);
        fork
            dev_run(1'b1, frame);
            begin
                repeat (4 * 2 * HALF) @(negedge clock);
                chk("busy_mid_data", host.busy, 1);
                host.send = 1'b1;
                host.cmd  = 8'hFF;
                @(negedge clock);
                host.send = 1'b0;
                host.cmd  = 8'h00;
            end
        join
        finish_xfer(frame, d0, e0);

        // reset pulse during bit 3, with send held during reset
        d0 = done_cnt; e0 = err_cnt;
        do_send(8'hA5);
        wait_start();
        dev_pulses(4);
        resetn    = 1'b0;
        host.send = 1'b1;
        host.cmd  = 8'h11;
        @(negedge clock);
        resetn    = 1'b1;
        host.send = 1'b0;
        host.cmd  = 8'h00;
        chk("abort_lines", {ps2_clock_oe, ps2_data_oe}, 2'b00);
        chk("abort_busy", host.busy, 0);
        repeat (5) @(negedge clock);
        chk("send_in_reset_ignored", host.busy, 0);
        chk("abort_done", done_cnt - d0, 0);
        chk("abort_error", err_cnt - e0, 0);

        // 8'hEE after the abort
        d0 = done_cnt; e0 = err_cnt;
        push_send(8'hEE, 1'b1, 1'b1);
        dev_run(1'b1, frame);
        finish_xfer(frame, d0, e0);
        chk("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
